// File: rtl/prefix_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// Module      : prefix_subtractor_pipe
// Description : Pipelined Kogge-Stone subtractor, diff = a - b - bin.
//               Borrow generate/propagate signals are combined by a
//               recursive-doubling network with one register stage per
//               doubling level. Valid/ready handshakes on both sides with a
//               global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module prefix_subtractor_pipe #(
    parameter  int WIDTH  = 8,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam logic [WIDTH-1:0] c_ones = {WIDTH{1'b1}};

    // Stage 0 .. LEVELS state: index 0 is the capture stage, index k holds
    // the result of doubling level k. Propagate is not needed after the last
    // level, so it is only kept up to LEVELS-1.
    logic             r_vld [0:LEVELS];
    logic [WIDTH-1:0] r_g   [0:LEVELS];
    logic [WIDTH-1:0] r_h   [0:LEVELS];
    logic             r_bin [0:LEVELS];
    logic [WIDTH-1:0] r_p   [0:LEVELS-1];

    // Output stage
    logic             r_out_vld;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_adv;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_h0;
    logic [WIDTH-1:0] w_cin;
    logic [WIDTH-1:0] w_diff;

    // Global stall: everything moves only when the output slot can be freed.
    assign w_adv    = ~r_out_vld | out_ready;
    assign in_ready = w_adv;

    // Bit-level borrow terms; bin acts as a generate below bit 0, so it is
    // folded into g_0 through p_0.
    assign w_p0 = ~(a ^ b);
    assign w_h0 = a ^ b;
    assign w_g0 = (~a & b) | {{(WIDTH-1){1'b0}}, w_p0[0] & bin};

    // Borrow into bit i is the group generate of bits [i-1:0]; bit 0 sees bin.
    assign w_cin  = {r_g[LEVELS][WIDTH-2:0], r_bin[LEVELS]};
    assign w_diff = r_h[LEVELS] ^ w_cin;

    // Capture stage plus the doubling levels; data only loads on an accepted
    // beat at the front so stale contents stay defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LEVELS; k++) begin
                r_vld[k] <= 1'b0;
                r_g[k]   <= '0;
                r_h[k]   <= '0;
                r_bin[k] <= 1'b0;
            end
            for (int k = 0; k < LEVELS; k++) begin
                r_p[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_g[0]   <= w_g0;
                r_p[0]   <= w_p0;
                r_h[0]   <= w_h0;
                r_bin[0] <= bin;
            end
            for (int k = 1; k <= LEVELS; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_g[k]   <= r_g[k-1] | (r_p[k-1] & (r_g[k-1] << (1 << (k-1))));
                r_h[k]   <= r_h[k-1];
                r_bin[k] <= r_bin[k-1];
            end
            for (int k = 1; k < LEVELS; k++) begin
                // Low d bits have no partner at distance d and pass through.
                r_p[k] <= r_p[k-1] &
                          ((r_p[k-1] << (1 << (k-1))) | (c_ones >> (WIDTH - (1 << (k-1)))));
            end
        end
    end

    // Output stage: final sum bits and borrow-out, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
        end else if (w_adv) begin
            r_out_vld <= r_vld[LEVELS];
            r_diff    <= w_diff;
            r_bout    <= r_g[LEVELS][WIDTH-1];
        end
    end

    assign out_valid = r_out_vld;
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule
`default_nettype wire
